ipvc_release_tracker: RTL and testbench

//   Downstream-router side of VC flow control. Per input port, tracks occupancy of each

---
 rtl/ipvc_release_tracker.sv | 99 +++++++++
 tb/tb_ipvc_release_tracker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ipvc_release_tracker.sv
// Downstream input-VC occupancy tracker. Frees a VC when its tail departs and
// returns one release pulse per freed VC upstream, one pulse per cycle per port.
module ipvc_port #(
  parameter int NUM_VCS = 4,
  parameter int CNT_W   = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_VCS-1:0] i_alloc,
  input  logic [NUM_VCS-1:0] i_tail,
  output logic [NUM_VCS-1:0] o_busy,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_rel,
  output logic               o_err
);
  // One spare bit so pending + new releases can exceed NUM_VCS before saturating.
  localparam int SW = CNT_W + 1;

  logic [NUM_VCS-1:0] r_busy, w_busy_nxt, w_rel;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]      w_rel_cnt, w_sum;
  logic               w_vc_err, w_sat;

  always_comb begin
    w_rel      = '0;
    w_rel_cnt  = '0;
    w_vc_err   = 1'b0;
    w_busy_nxt = r_busy;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_rel[v]  = i_tail[v] & r_busy[v];
      w_rel_cnt = w_rel_cnt + SW'(w_rel[v]);
      if (r_busy[v]) begin
        // Alloc on a busy VC keeps it busy even if its tail leaves this cycle.
        if (i_alloc[v])     w_vc_err      = 1'b1;
        else if (i_tail[v]) w_busy_nxt[v] = 1'b0;
      end else begin
        if (i_tail[v])  w_vc_err      = 1'b1;
        if (i_alloc[v]) w_busy_nxt[v] = 1'b1;
      end
    end
    w_sum     = SW'(r_cnt) - SW'(r_cnt != '0) + w_rel_cnt;
    w_sat     = (w_sum > SW'(NUM_VCS));
    w_cnt_nxt = w_sat ? CNT_W'(NUM_VCS) : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_busy = r_busy;
  assign o_cnt  = r_cnt;
  assign o_rel  = (r_cnt != '0);
  assign o_err  = w_vc_err | w_sat;
endmodule

module ipvc_release_tracker #(
  parameter int NUM_PORTS = 5,
  parameter int NUM_VCS   = 4,
  parameter int CNT_W     = $clog2(NUM_VCS + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_VCS*NUM_PORTS-1:0] i_vc_alloc,
  input  logic [NUM_VCS*NUM_PORTS-1:0] i_tail_depart,
  output logic [NUM_PORTS-1:0]         o_vc_release_out,
  output logic [NUM_VCS*NUM_PORTS-1:0] o_ipvc_busy,
  output logic [CNT_W*NUM_PORTS-1:0]   o_pending_cnt,
  output logic                         o_protocol_err
);
  logic [NUM_PORTS-1:0] w_port_err;
  logic                 r_err;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ipvc_port #(.NUM_VCS(NUM_VCS), .CNT_W(CNT_W)) u_port (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_alloc (i_vc_alloc[p*NUM_VCS +: NUM_VCS]),
      .i_tail  (i_tail_depart[p*NUM_VCS +: NUM_VCS]),
      .o_busy  (o_ipvc_busy[p*NUM_VCS +: NUM_VCS]),
      .o_cnt   (o_pending_cnt[p*CNT_W +: CNT_W]),
      .o_rel   (o_vc_release_out[p]),
      .o_err   (w_port_err[p])
    );
  end

  // Sticky: only reset clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_err <= 1'b0;
    else          r_err <= r_err | (|w_port_err);
  end

  assign o_protocol_err = r_err;
endmodule

// File: tb/tb_ipvc_release_tracker.sv
// Directed scoreboard bench: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_ipvc_release_tracker;
  localparam int NP = 5, NV = 4, CW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NV*NP-1:0] alloc = '0, tail = '0;
  logic [NP-1:0]    rel_out;
  logic [NV*NP-1:0] busy;
  logic [CW*NP-1:0] pend;
  logic             perr;

  ipvc_release_tracker #(.NUM_PORTS(NP), .NUM_VCS(NV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vc_alloc(alloc), .i_tail_depart(tail),
    .o_vc_release_out(rel_out), .o_ipvc_busy(busy), .o_pending_cnt(pend),
    .o_protocol_err(perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic [NV*NP-1:0] busy;
    logic [CW*NP-1:0] pend;
    logic [NP-1:0]    rel;
    logic             err;
    string            name;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_fail = 0;

  function automatic logic [CW*NP-1:0] pc(int p, int v);
    logic [CW*NP-1:0] r;
    r = '0;
    r[CW*p +: CW] = CW'(v);
    return r;
  endfunction

  task automatic push(input logic [NV*NP-1:0] b, input logic [CW*NP-1:0] pd,
                      input logic [NP-1:0] r, input logic e, input string nm);
    exp_t x;
    x.cyc = cyc + 1; x.busy = b; x.pend = pd; x.rel = r; x.err = e; x.name = nm;
    q.push_back(x);
  endtask

  // Drive inputs for one cycle; expectation applies to the following cycle.
  task automatic step(input logic [NV*NP-1:0] a, input logic [NV*NP-1:0] t,
                      input logic [NV*NP-1:0] b, input logic [CW*NP-1:0] pd,
                      input logic [NP-1:0] r, input logic e, input string nm);
    push(b, pd, r, e, nm);
    alloc = a; tail = t;
    @(posedge clk); #1;
    alloc = '0; tail = '0;
  endtask

  task automatic do_reset(input string nm);
    push('0, '0, '0, 1'b0, nm);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t x;
      x = q.pop_front();
      if (x.cyc < cyc) begin
        n_cmp++; n_fail++;
        $display("FAIL %s: check for cycle %0d missed at cycle %0d", x.name, x.cyc, cyc);
      end else begin
        n_cmp++;
        if (busy !== x.busy) begin
          n_fail++;
          $display("FAIL %s busy: got %h want %h (cyc %0d)", x.name, busy, x.busy, cyc);
        end
        n_cmp++;
        if (pend !== x.pend) begin
          n_fail++;
          $display("FAIL %s pending: got %h want %h (cyc %0d)", x.name, pend, x.pend, cyc);
        end
        n_cmp++;
        if (rel_out !== x.rel) begin
          n_fail++;
          $display("FAIL %s release: got %b want %b (cyc %0d)", x.name, rel_out, x.rel, cyc);
        end
        n_cmp++;
        if (perr !== x.err) begin
          n_fail++;
          $display("FAIL %s err: got %b want %b (cyc %0d)", x.name, perr, x.err, cyc);
        end
      end
    end
  end

  initial begin
    // Reset held 2 cycles with random inputs.
    #1;
    alloc = 20'($urandom); tail = 20'($urandom);
    @(posedge clk); #1;
    alloc = 20'($urandom); tail = 20'($urandom);
    push('0, '0, '0, 1'b0, "reset_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step('0, '0, '0, '0, '0, 1'b0, "reset_release");

    // Single packet on port 0 VC1.
    step(20'h2, '0, 20'h2, '0, '0, 1'b0, "single_t1");
    for (int i = 2; i <= 5; i++) step('0, '0, 20'h2, '0, '0, 1'b0, "single_busy");
    step('0, 20'h2, '0, pc(0, 1), 5'b00001, 1'b0, "single_pulse");
    step('0, '0, '0, '0, '0, 1'b0, "single_after");

    // Burst of 4 on port 2.
    step(20'hF00, '0, 20'hF00, '0, '0, 1'b0, "burst_alloc");
    step('0, 20'hF00, '0, pc(2, 4), 5'b00100, 1'b0, "burst_4");
    step('0, '0, '0, pc(2, 3), 5'b00100, 1'b0, "burst_3");
    step('0, '0, '0, pc(2, 2), 5'b00100, 1'b0, "burst_2");
    step('0, '0, '0, pc(2, 1), 5'b00100, 1'b0, "burst_1");
    step('0, '0, '0, '0, '0, 1'b0, "burst_done");

    // Overlapping releases on port 1.
    step(20'h70, '0, 20'h70, '0, '0, 1'b0, "ovl_alloc");
    step('0, 20'h30, 20'h40, pc(1, 2), 5'b00010, 1'b0, "ovl_a");
    step('0, 20'h40, '0, pc(1, 2), 5'b00010, 1'b0, "ovl_b");
    step('0, '0, '0, pc(1, 1), 5'b00010, 1'b0, "ovl_c");
    step('0, '0, '0, '0, '0, 1'b0, "ovl_d");

    // Reset mid-drain on port 3 with port 4 VC0 still busy.
    step(20'h17000, '0, 20'h17000, '0, '0, 1'b0, "mid_alloc");
    step('0, 20'h07000, 20'h10000, pc(3, 3), 5'b01000, 1'b0, "mid_pend3");
    do_reset("mid_reset");
    for (int i = 0; i < 3; i++) step('0, '0, '0, '0, '0, 1'b0, "mid_quiet");

    // Tail on idle VC: no pulse, sticky error.
    step('0, 20'h1, '0, '0, '0, 1'b1, "err_idle_tail");
    step('0, '0, '0, '0, '0, 1'b1, "err_held");
    do_reset("err_reset");

    // Alloc on busy VC, then alloc+tail on busy VC still releases.
    step(20'h20, '0, 20'h20, '0, '0, 1'b0, "dup_alloc1");
    step(20'h20, '0, 20'h20, '0, '0, 1'b1, "dup_alloc2");
    step(20'h20, 20'h20, 20'h20, pc(1, 1), 5'b00010, 1'b1, "alloc_tail_busy");
    step('0, 20'h20, '0, pc(1, 1), 5'b00010, 1'b1, "dup_tail");
    step('0, '0, '0, '0, '0, 1'b1, "dup_done");
    do_reset("sat_reset");

    // Counter saturates at NUM_VCS.
    step(20'hF, '0, 20'hF, '0, '0, 1'b0, "sat_alloc");
    step(20'hF, 20'hF, 20'hF, pc(0, 4), 5'b00001, 1'b1, "sat_first");
    step('0, 20'hF, '0, pc(0, 4), 5'b00001, 1'b1, "sat_clip");
    step('0, '0, '0, pc(0, 3), 5'b00001, 1'b1, "sat_3");
    step('0, '0, '0, pc(0, 2), 5'b00001, 1'b1, "sat_2");
    step('0, '0, '0, pc(0, 1), 5'b00001, 1'b1, "sat_1");
    step('0, '0, '0, '0, '0, 1'b1, "sat_0");

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: %0d checks left unconsumed, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
